// File: rtl/capture_rle_pkg.sv
// Shared types and constants for the capture_rle sample-capture front end.
// Build option CAPTURE_RLE_TRIGGER_EN is consumed in capture_rle.sv.
package capture_rle_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_COUNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_CAPTURE   = 2'd2
   } state_e;

   // Largest encodable run count for a counter of width w (capped at 32 bits).
   function automatic logic [31:0] count_max(input int unsigned w);
      if (w >= 32) begin
         return '1;
      end
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/capture_sync.sv
// Two-flop synchroniser for the asynchronous logic-analyser input pins.
module capture_sync
   import capture_rle_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/capture_rle.sv
// Trigger-gated run-length encoder feeding a single-entry valid/accept output register.
// Define CAPTURE_RLE_TRIGGER_EN to enable the trigger compare; otherwise capture starts on enable.
module capture_rle
   import capture_rle_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [WIDTH-1:0]         input_i,
   input  logic                     enable_i,
   input  logic [WIDTH-1:0]         trig_mask_i,
   input  logic [WIDTH-1:0]         trig_value_i,
   output logic [COUNT_W+WIDTH-1:0] data_o,
   output logic                     valid_o,
   input  logic                     accept_i,
   output logic                     triggered_o,
   output logic                     overflow_o
);

   localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(count_max(COUNT_W));

   logic [WIDTH-1:0]         sample;
   state_e                   state_q, state_d;
   logic [WIDTH-1:0]         prev_q, prev_d;
   logic [COUNT_W-1:0]       count_q, count_d;
   logic [COUNT_W+WIDTH-1:0] data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     trig_q, trig_d;
   logic                     ovf_q, ovf_d;
   logic                     emit;

   capture_sync #(.WIDTH(WIDTH)) u_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (input_i),
      .sync_o  (sample)
   );

`ifdef CAPTURE_RLE_TRIGGER_EN
   logic trig_match;
   assign trig_match = ((sample & trig_mask_i) == (trig_value_i & trig_mask_i));
`else
   logic unused_trig;
   assign unused_trig = ^{trig_mask_i, trig_value_i};
`endif

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = valid_q;
      trig_d  = trig_q;
      ovf_d   = ovf_q;
      emit    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               ovf_d = 1'b0;
`ifdef CAPTURE_RLE_TRIGGER_EN
               trig_d  = 1'b0;
               state_d = ST_WAIT_TRIG;
`else
               trig_d  = 1'b1;
               state_d = ST_CAPTURE;
               prev_d  = sample;
               count_d = '0;
`endif
            end
         end
         ST_WAIT_TRIG: begin
`ifdef CAPTURE_RLE_TRIGGER_EN
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (trig_match) begin
               state_d = ST_CAPTURE;
               trig_d  = 1'b1;
               prev_d  = sample;
               count_d = '0;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_CAPTURE: begin
            if (!enable_i) begin
               emit    = 1'b1;
               state_d = ST_IDLE;
            end else if (sample == prev_q && count_q != CNT_MAX) begin
               count_d = count_q + COUNT_W'(1);
            end else begin
               // Sample change or saturated run: close the run, start a new one.
               emit    = 1'b1;
               prev_d  = sample;
               count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A word that finds the register full and not being taken is dropped.
      if (emit) begin
         if (!valid_q || accept_i) begin
            data_d  = {count_q, prev_q};
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && accept_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         prev_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         trig_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         trig_q  <= trig_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign triggered_o = trig_q;
   assign overflow_o  = ovf_q;

endmodule
